// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: system-side write port, queue status and transmitter handshake
interface uart_tx_queue_if #(parameter int DEPTH_LOG2 = 4);
  logic                wr;
  logic [7:0]          wdata;
  logic                flush;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                tx_send;
  logic [7:0]          tx_data;
  logic                tx_busy;
  modport master (
    output wr, wdata, flush, tx_busy,
    input  full, empty, count, overflow, tx_send, tx_data
  );
  modport slave (
    input  wr, wdata, flush, tx_busy,
    output full, empty, count, overflow, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through its send/busy handshake
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic            ref_clk,
  input logic            reset,
  uart_tx_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {Q_IDLE, Q_REQ, Q_WAIT} state_t;
  state_t                state, state_nx;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            data;
  logic                  push, pop, ovf, send;
  assign bus.full     = count == (DEPTH_LOG2+1)'(DEPTH);
  assign bus.empty    = count == '0;
  assign bus.count    = count;
  assign bus.overflow = ovf;
  assign bus.tx_send  = send;
  assign bus.tx_data  = data;
  assign push = bus.wr && !bus.full && !bus.flush;
  // state register; async reset drops tx_send immediately
  always_ff @(posedge ref_clk or posedge reset)
    if (reset) state <= Q_IDLE;
    else       state <= state_nx;
  // next state: launch from idle, wait for busy to rise, then to fall
  always_comb begin
    state_nx = (state == Q_IDLE) ? (pop ? Q_REQ : Q_IDLE) :
               (state == Q_REQ)  ? (bus.tx_busy ? Q_WAIT : Q_REQ) :
                                   (bus.tx_busy ? Q_WAIT : Q_IDLE);
  end
  // outputs: send while requesting; pop the head only into an idle transmitter and never on flush
  always_comb begin
    send = state == Q_REQ;
    pop  = state == Q_IDLE && !bus.empty && !bus.tx_busy && !bus.flush;
  end
  // storage array, contents need no reset
  always_ff @(posedge ref_clk)
    if (push) mem[wptr] <= bus.wdata;
  // pointers, occupancy and the dropped-write pulse; flush discards queued bytes only
  always_ff @(posedge ref_clk or posedge reset)
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (bus.flush) begin
      rptr  <= wptr;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      wptr  <= wptr + DEPTH_LOG2'(push);
      rptr  <= rptr + DEPTH_LOG2'(pop);
      count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      ovf   <= bus.wr && bus.full;
    end
  // launched byte register, held until the next launch
  always_ff @(posedge ref_clk or posedge reset)
    if (reset)    data <= 8'h00;
    else if (pop) data <= mem[rptr];
endmodule
